// File: rtl/spike_threshold_reset.sv
// ============================================================================
// Module  : spike_threshold_reset
// Brief   : Float threshold compare, spike emit, reset/passthrough writeback
//           and per-neuron refractory counting. Optional SPIKE_COUNT_EN macro
//           adds per-neuron 16-bit saturating spike counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_threshold_reset #(
    parameter int          NUM_NEURONS = 4,
    parameter int          REFRACT_W   = 4,
    parameter logic [31:0] THRESH_INIT = 32'h41F00000,
    parameter logic [31:0] VRESET_INIT = 32'h00000000,
    localparam int         AW          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 cfg_we,
    input  logic [31:0]          cfg_threshold,
    input  logic [31:0]          cfg_vreset,
    input  logic [REFRACT_W-1:0] cfg_refract,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AW-1:0]        in_addr,
    input  logic [31:0]          in_potential,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AW-1:0]        out_addr,
    output logic [31:0]          out_potential,
    output logic                 out_spike,
`ifdef SPIKE_COUNT_EN
    input  logic                 cnt_clr,
    input  logic [AW-1:0]        cnt_addr,
    output logic [15:0]          cnt_value,
`endif
    output logic                 busy
);

    logic [31:0]          threshold;
    logic [31:0]          v_reset;
    logic [REFRACT_W-1:0] refract_steps;
    logic [REFRACT_W-1:0] refr_cnt [NUM_NEURONS];

    logic                 accept;
    logic                 in_range;
    logic [REFRACT_W-1:0] cur_cnt;
    logic                 spike_cond;
    logic                 next_spike;
    logic [31:0]          next_pot;

    // Sign-magnitude P >= T without an adder; NaN never compares true.
    function automatic logic float_ge(input logic [31:0] p, input logic [31:0] t);
        logic nan_p, nan_t;
        nan_p = (p[30:23] == 8'hFF) && (p[22:0] != 23'd0);
        nan_t = (t[30:23] == 8'hFF) && (t[22:0] != 23'd0);
        if (nan_p || nan_t)
            return 1'b0;
        if ((p[30:0] == 31'd0) && (t[30:0] == 31'd0))
            return 1'b1;
        case ({p[31], t[31]})
            2'b00:   return p[30:0] >= t[30:0];
            2'b11:   return p[30:0] <= t[30:0];
            2'b01:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign busy       = out_valid || cfg_we;
    assign in_range   = {{(32-AW){1'b0}}, in_addr} < 32'(NUM_NEURONS);
    assign cur_cnt    = in_range ? refr_cnt[in_addr] : '0;
    assign spike_cond = float_ge(in_potential, threshold);

    always_comb begin
        next_spike = 1'b0;
        next_pot   = in_potential;
        if (in_range) begin
            if (cur_cnt != '0) begin
                next_pot = v_reset;
            end else if (spike_cond) begin
                next_spike = 1'b1;
                next_pot   = v_reset;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            threshold     <= THRESH_INIT;
            v_reset       <= VRESET_INIT;
            refract_steps <= '0;
        end else if (cfg_we) begin
            threshold     <= cfg_threshold;
            v_reset       <= cfg_vreset;
            refract_steps <= cfg_refract;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_valid     <= 1'b0;
            out_spike     <= 1'b0;
            out_addr      <= '0;
            out_potential <= '0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_spike     <= next_spike;
            out_addr      <= in_addr;
            out_potential <= next_pot;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

    // Counters move only on accepts for their own neuron: one step per timestep.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_NEURONS; i++)
                refr_cnt[i] <= '0;
        end else if (accept && in_range) begin
            if (cur_cnt != '0)
                refr_cnt[in_addr] <= cur_cnt - 1'b1;
            else if (spike_cond)
                refr_cnt[in_addr] <= refract_steps;
        end
    end

`ifdef SPIKE_COUNT_EN
    logic [15:0] spike_cnt [NUM_NEURONS];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_NEURONS; i++)
                spike_cnt[i] <= '0;
        end else if (cnt_clr) begin
            for (int i = 0; i < NUM_NEURONS; i++)
                spike_cnt[i] <= '0;
        end else if (accept && next_spike && (spike_cnt[in_addr] != 16'hFFFF)) begin
            spike_cnt[in_addr] <= spike_cnt[in_addr] + 16'd1;
        end
    end

    assign cnt_value = ({{(32-AW){1'b0}}, cnt_addr} < 32'(NUM_NEURONS)) ? spike_cnt[cnt_addr] : 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spike_threshold_reset.sv
// ============================================================================
// Module  : tb_spike_threshold_reset
// Brief   : Directed self-checking bench for spike_threshold_reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spike_threshold_reset;

    localparam int AW = 2;
    localparam int RW = 4;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          cfg_we = 1'b0;
    logic [31:0]   cfg_threshold = 32'h41F00000;
    logic [31:0]   cfg_vreset = 32'h0;
    logic [RW-1:0] cfg_refract = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_addr = '0;
    logic [31:0]   in_potential = 32'h0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_potential;
    logic          out_spike;
    logic          busy;
`ifdef SPIKE_COUNT_EN
    logic          cnt_clr = 1'b0;
    logic [AW-1:0] cnt_addr = 2'd1;
    logic [15:0]   cnt_value;
`endif

    int checks = 0;
    int failures = 0;

    spike_threshold_reset dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .cfg_we(cfg_we), .cfg_threshold(cfg_threshold), .cfg_vreset(cfg_vreset),
        .cfg_refract(cfg_refract),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_potential(in_potential),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_potential(out_potential), .out_spike(out_spike),
`ifdef SPIKE_COUNT_EN
        .cnt_clr(cnt_clr), .cnt_addr(cnt_addr), .cnt_value(cnt_value),
`endif
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic config_write(input logic [31:0] th, input logic [31:0] vr, input logic [RW-1:0] rf);
        cfg_we = 1'b1; cfg_threshold = th; cfg_vreset = vr; cfg_refract = rf;
        @(posedge CLK); #1;
        cfg_we = 1'b0;
    endtask

    // One accept with out_ready high; result inspected 1 ns after the edge.
    task automatic xfer(input string name, input logic [AW-1:0] a, input logic [31:0] p,
                        input logic exp_spike, input logic [31:0] exp_pot);
        in_valid = 1'b1; in_addr = a; in_potential = p;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_spike !== exp_spike || out_potential !== exp_pot || out_addr !== a) begin
            failures++;
            $display("FAIL %s: got valid=%b spike=%b pot=%h addr=%0d, want valid=1 spike=%b pot=%h addr=%0d",
                     name, out_valid, out_spike, out_potential, out_addr, exp_spike, exp_pot, a);
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_spike !== 1'b0 || out_addr !== '0 || out_potential !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b spike=%b addr=%0d pot=%h, want all 0",
                     out_valid, out_spike, out_addr, out_potential);
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got in_ready=%b busy=%b, want 1 0", in_ready, busy);
        end
        RESET_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_passthrough();
        xfer("pass_27p86", 2'd0, 32'h41DED852, 1'b0, 32'h41DED852);
        @(posedge CLK); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_refract();
        config_write(32'h41F00000, 32'h0, 4'd2);
        xfer("refr_spike",  2'd1, 32'h42000000, 1'b1, 32'h0);
        xfer("refr_hold1",  2'd1, 32'h42400000, 1'b0, 32'h0);
        xfer("refr_hold2",  2'd1, 32'h42400000, 1'b0, 32'h0);
        xfer("refr_respike", 2'd1, 32'h42400000, 1'b1, 32'h0);
    endtask

    task automatic test_compare();
        config_write(32'h41F00000, 32'h0, 4'd0);
        xfer("cmp_neg5",  2'd2, 32'hC0A00000, 1'b0, 32'hC0A00000);
        xfer("cmp_equal", 2'd2, 32'h41F00000, 1'b1, 32'h0);
        xfer("cmp_nan",   2'd2, 32'h7FC00000, 1'b0, 32'h7FC00000);
        xfer("cmp_inf",   2'd2, 32'h7F800000, 1'b1, 32'h0);
    endtask

    task automatic test_config_same_edge();
        // Accept and config write on the same edge: old threshold 30.0 applies.
        cfg_we = 1'b1; cfg_threshold = 32'h42200000; cfg_vreset = 32'h0; cfg_refract = '0;
        xfer("cfg_old_used", 2'd3, 32'h42000000, 1'b1, 32'h0);
        cfg_we = 1'b0;
        xfer("cfg_new_used", 2'd3, 32'h42000000, 1'b0, 32'h42000000);
    endtask

    task automatic test_neg_threshold();
        config_write(32'hC1200000, 32'hBF800000, 4'd0);
        xfer("neg_m5",   2'd2, 32'hC0A00000, 1'b1, 32'hBF800000);
        xfer("neg_m20",  2'd2, 32'hC1A00000, 1'b0, 32'hC1A00000);
        xfer("neg_mzero", 2'd2, 32'h80000000, 1'b1, 32'hBF800000);
    endtask

    task automatic test_backpressure();
        config_write(32'h41F00000, 32'h0, 4'd0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_addr = 2'd0; in_potential = 32'h3F800000;
        @(posedge CLK); #1;
        in_addr = 2'd2; in_potential = 32'h40000000;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL bp_stall: got in_ready=%b out_valid=%b busy=%b, want 0 1 1", in_ready, out_valid, busy);
        end
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (out_potential !== 32'h3F800000 || out_addr !== 2'd0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_stable: got pot=%h addr=%0d valid=%b, want 3f800000 0 1",
                     out_potential, out_addr, out_valid);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready: got in_ready=%b, want 1", in_ready);
        end
        @(posedge CLK); #1;
        checks++;
        if (out_valid !== 1'b1 || out_potential !== 32'h40000000 || out_addr !== 2'd2) begin
            failures++;
            $display("FAIL bp_second: got valid=%b pot=%h addr=%0d, want 1 40000000 2",
                     out_valid, out_potential, out_addr);
        end
        in_addr = 2'd3; in_potential = 32'h40400000;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_potential !== 32'h40400000 || out_addr !== 2'd3) begin
            failures++;
            $display("FAIL bp_third: got valid=%b pot=%h addr=%0d, want 1 40400000 3",
                     out_valid, out_potential, out_addr);
        end
        @(posedge CLK); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_mid_reset();
        // Neuron 1 was left with refractory count 2; this accept leaves it at 1.
        config_write(32'h41F00000, 32'h0, 4'd2);
        out_ready = 1'b0;
        in_valid = 1'b1; in_addr = 2'd1; in_potential = 32'h42000000;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_spike !== 1'b0 || out_potential !== 32'h0) begin
            failures++;
            $display("FAIL mr_refract_held: got valid=%b spike=%b pot=%h, want 1 0 00000000",
                     out_valid, out_spike, out_potential);
        end
        #2;
        RESET_N = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_spike !== 1'b0 || out_potential !== 32'h0 || out_addr !== '0) begin
            failures++;
            $display("FAIL mr_async: got valid=%b spike=%b pot=%h addr=%0d, want all 0",
                     out_valid, out_spike, out_potential, out_addr);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        out_ready = 1'b1;
        @(posedge CLK); #1;
`ifdef SPIKE_COUNT_EN
        checks++;
        if (cnt_value !== 16'd0) begin
            failures++;
            $display("FAIL cnt_after_reset: got %0d, want 0", cnt_value);
        end
`endif
        xfer("mr_respike", 2'd1, 32'h42000000, 1'b1, 32'h0);
`ifdef SPIKE_COUNT_EN
        checks++;
        if (cnt_value !== 16'd1) begin
            failures++;
            $display("FAIL cnt_after_spike: got %0d, want 1", cnt_value);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_refract();
        test_compare();
        test_config_same_edge();
        test_neg_threshold();
        test_backpressure();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 ns");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/spike_threshold_reset.md
Name: spike_threshold_reset

Overview:
- Downstream neighbour of the LIF decay stage.
- Consumes each neuron's post-decay IEEE-754 single-precision membrane potential, compares it to a configurable threshold, emits a spike, and returns the reset or passthrough potential for writeback.
- Enforces a per-neuron refractory period counted in timesteps.
- Sits between the decay stage and the potential memory/spike-packet logic of the 4-neuron accelerator.

Parameters:
- NUM_NEURONS, 4, neurons tracked; address width is clog2(NUM_NEURONS), minimum 1.
- REFRACT_W, 4, width of per-neuron refractory counter.
- THRESH_INIT, 32'h41F00000, threshold reset value (30.0).
- VRESET_INIT, 32'h00000000, reset-potential reset value (+0.0).

Ports:
- CLK  input  1  system clock.
- RESET_N  input  1  asynchronous active-low reset.
- cfg_we  input  1  write threshold, v_reset and refract_steps this cycle.
- cfg_threshold  input  32  threshold (float).
- cfg_vreset  input  32  reset potential (float).
- cfg_refract  input  REFRACT_W  refractory timesteps after a spike.
- in_valid  input  1  decayed potential valid.
- in_ready  output  1  stage can accept.
- in_addr  input  AW  neuron address.
- in_potential  input  32  decayed potential.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts.
- out_addr  output  AW  neuron address of result.
- out_potential  output  32  potential to write back.
- out_spike  output  1  spike flag for this neuron/timestep.
- busy  output  1  out_valid held or config write pending.

Behaviour:
- Reset (async, RESET_N=0):
  - out_valid, out_spike, out_addr, out_potential go to 0.
  - All refractory counters go to 0.
  - Threshold, v_reset and refract go to THRESH_INIT, VRESET_INIT and 0.
- Handshake:
  - Single output register; in_ready = !out_valid || out_ready.
  - Transfer occurs when in_valid && in_ready. Result is registered on that edge, giving 1-cycle latency.
  - out_valid stays high, with all out_* stable, until out_ready is sampled high.
  - Full throughput: one accept per cycle when out_ready stays high.
- Float compare (combinational, no adder):
  - spike_cond = (P >= T).
  - Sign-magnitude rules:
    - Both non-negative: unsigned compare of bits [30:0].
    - Both negative: reversed compare.
    - Signs differ: the positive value is larger.
    - +0 equals -0.
  - NaN on either operand (exp=8'hFF, mantissa!=0) gives spike_cond=0. +Inf >= any finite value.
- Per-neuron state machine on accept (refractory counter r[in_addr]):
  - IDLE (r==0):
    - If spike_cond: out_spike=1, out_potential=v_reset, r<=cfg refract value.
    - Else: out_spike=0, out_potential=in_potential.
  - REFRACT (r!=0): out_spike=0, out_potential=v_reset, r<=r-1, regardless of spike_cond.
  - Counter decrements only on accepts for that neuron, i.e. once per timestep per neuron. It saturates at 0 and never wraps.
  - refract=0 means a neuron may spike on consecutive timesteps.
- Config:
  - cfg_we takes effect on the clock edge.
  - An accept on the same edge uses the old config values; the new values apply from the next accept.
  - Config writes never alter refractory counters already loaded.
- Simultaneous events:
  - An accept and an output drain on the same edge replace the register contents with no bubble.
  - Out-of-range in_addr (>= NUM_NEURONS) passes through unchanged with out_spike=0 and touches no counter.
- Reset mid-operation: an in-flight result is discarded and out_valid drops immediately.

Optional Feature:
- SPIKE_COUNT_EN: adds per-neuron 16-bit saturating spike counters, plus ports cnt_clr (input 1), cnt_addr (input AW) and cnt_value (output 16).
  - Each counter increments on every accepted result with out_spike=1, and saturates at 16'hFFFF.
  - cnt_clr zeroes all counters synchronously; clear wins over a same-cycle increment.
  - cnt_value is combinational readback of counter[cnt_addr].
  - Counters reset to 0 on RESET_N.
- Without the macro, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then default config; in_potential=32'h41DED852 (27.86), addr 0 -> next cycle out_valid=1, out_spike=0, out_potential=32'h41DED852.
- in_potential=32'h42000000 (32.0), addr 1, cfg_refract=2 -> out_spike=1, out_potential=32'h00000000. Next two addr-1 inputs of 32'h42400000 give spike=0 with v_reset output; the third gives spike=1.
- Sign/edge values vs threshold 30.0:
  - 32'hC0A00000 (-5.0) -> no spike.
  - 32'h41F00000 (equal) -> spike.
  - 32'h7FC00000 (NaN) -> no spike.
  - 32'h7F800000 (+Inf) -> spike.
- Threshold=32'hC1200000 (-10.0): input 32'hC0A00000 -> spike; input 32'hC1A00000 (-20.0) -> no spike; input 32'h80000000 (-0) -> spike.
- Backpressure: hold out_ready=0 with in_valid=1 -> in_ready=0 and out_* stable. Release -> one transfer per cycle with no lost or duplicated results.
- Assert RESET_N=0 while refractory and out_valid are set -> outputs go to 0 immediately. After release, addr 1 at 32.0 spikes again (counter cleared). With SPIKE_COUNT_EN, cnt_value for addr 1 reads 0, then 1 after that spike.
